// File: rtl/rec_id_pkg.sv
// Receive identifier capture: shared widths, counter size and FSM state encoding.
package rec_id_pkg;

   localparam int unsigned DEF_BASEW = 11;   // base identifier bits after SOF
   localparam int unsigned DEF_EXTW  = 18;   // extended identifier bits after IDE=1
   localparam int unsigned DEF_REGW  = 16;   // width of each arbitration output word
   localparam int unsigned CNTW      = 5;    // bit counter width, covers the longest field

   // Arbitration-field walk plus the post-frame hold and register-write cycles.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_BASE   = 3'd1,
      ST_SRRRTR = 3'd2,
      ST_IDE    = 3'd3,
      ST_EXT    = 3'd4,
      ST_RTR2   = 3'd5,
      ST_HOLD   = 3'd6,
      ST_WRITE  = 3'd7
   } state_t;

endpackage

// File: rtl/rec_id_shift.sv
// Generic W-bit MSB-first shift register with synchronous clear.
// Ports:
//   clk      in  1  system clock
//   rst      in  1  synchronous reset, active-low
//   i_clr    in  1  clear contents (wins over shift)
//   i_shift  in  1  shift i_bit in at the LSB end
//   i_bit    in  1  serial input bit
//   o_q      out W  register contents, first bit shifted in ends up at the MSB
module rec_id_shift #(
   parameter int unsigned W = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_shift,
   input  logic         i_bit,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= '0;
      end else if (i_shift) begin
         r_q <= {r_q[W-2:0], i_bit};
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/rec_id_capture.sv
// Receive-side identifier capture. Assembles base/ext ID, IDE and RTR from the
// destuffed arbitration-field bit stream, flags a complete ID, and in promiscuous
// mode loads the two arbitration words and pulses their write strobes after a good frame.
// Ports:
//   clk       in  1   system clock
//   rst       in  1   synchronous reset, active-low
//   sof       in  1   start-of-frame pulse (hard sync)
//   smpl      in  1   rxbit holds a valid destuffed bit
//   rxbit     in  1   received bit, 1 = recessive
//   prom      in  1   promiscuous mode, sampled with rec_ok
//   rec_ok    in  1   frame received without error
//   rec_err   in  1   error frame / abort
//   recid2_o  out 16  {base_id, ext_id[17:13]}
//   recid1_o  out 16  {ext_id[12:0], ide, rtr, 1'b0}
//   can2_o    out 1   write strobe, arbitration register 2
//   can1_o    out 1   write strobe, arbitration register 1
//   id_valid  out 1   pulse, complete ID captured
//   busy      out 1   high while not idle
module rec_id_capture
   import rec_id_pkg::*;
#(
   parameter int unsigned BASEW = DEF_BASEW,
   parameter int unsigned EXTW  = DEF_EXTW,
   parameter int unsigned REGW  = DEF_REGW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sof,
   input  logic            smpl,
   input  logic            rxbit,
   input  logic            prom,
   input  logic            rec_ok,
   input  logic            rec_err,
   output logic [REGW-1:0] recid2_o,
   output logic [REGW-1:0] recid1_o,
   output logic            can2_o,
   output logic            can1_o,
   output logic            id_valid,
   output logic            busy
);

   // Both words together hold base, ext, ide, rtr and one reserved zero bit.
   localparam int unsigned WORDW = BASEW + EXTW + 3;

   state_t            r_state, w_state_nxt;
   logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
   logic              r_ide, w_ide_nxt;
   logic              r_rtr, w_rtr_nxt;
   logic              r_rtr_tmp, w_rtr_tmp_nxt;
   logic              w_clr_all, w_ext_clr;
   logic              w_base_shift, w_ext_shift;
   logic              w_id_valid_nxt, w_load;
   logic [BASEW-1:0]  w_base_id;
   logic [EXTW-1:0]   w_ext_id;
   logic [WORDW-1:0]  w_word;
   logic [REGW-1:0]   r_recid2, r_recid1;
   logic              r_can, r_id_valid, r_busy;

   // Field shift registers
   rec_id_shift #(.W(BASEW)) u_base (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr_all),
      .i_shift (w_base_shift),
      .i_bit   (rxbit),
      .o_q     (w_base_id)
   );

   rec_id_shift #(.W(EXTW)) u_ext (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_clr_all | w_ext_clr),
      .i_shift (w_ext_shift),
      .i_bit   (rxbit),
      .o_q     (w_ext_id)
   );

   // State, counter and flag registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_ide     <= 1'b0;
         r_rtr     <= 1'b0;
         r_rtr_tmp <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ide     <= w_ide_nxt;
         r_rtr     <= w_rtr_nxt;
         r_rtr_tmp <= w_rtr_tmp_nxt;
      end
   end

   // Next-state and control decode; rec_err > sof > rec_ok > smpl
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_ide_nxt      = r_ide;
      w_rtr_nxt      = r_rtr;
      w_rtr_tmp_nxt  = r_rtr_tmp;
      w_clr_all      = 1'b0;
      w_ext_clr      = 1'b0;
      w_base_shift   = 1'b0;
      w_ext_shift    = 1'b0;
      w_id_valid_nxt = 1'b0;
      w_load         = 1'b0;

      if (rec_err) begin
         w_state_nxt = ST_IDLE;
      end else if (sof && (r_state != ST_WRITE)) begin
         // Hard sync: any partial ID is dropped
         w_state_nxt   = ST_BASE;
         w_cnt_nxt     = '0;
         w_clr_all     = 1'b1;
         w_ide_nxt     = 1'b0;
         w_rtr_nxt     = 1'b0;
         w_rtr_tmp_nxt = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: ;
            ST_BASE: begin
               if (smpl) begin
                  w_base_shift = 1'b1;
                  w_cnt_nxt    = r_cnt + CNTW'(1);
                  if (r_cnt == CNTW'(BASEW - 1)) w_state_nxt = ST_SRRRTR;
               end
            end
            ST_SRRRTR: begin
               // RTR for a standard frame, SRR for an extended one
               if (smpl) begin
                  w_rtr_tmp_nxt = rxbit;
                  w_state_nxt   = ST_IDE;
               end
            end
            ST_IDE: begin
               if (smpl) begin
                  w_ide_nxt = rxbit;
                  if (!rxbit) begin
                     w_rtr_nxt      = r_rtr_tmp;
                     w_ext_clr      = 1'b1;
                     w_id_valid_nxt = 1'b1;
                     w_state_nxt    = ST_HOLD;
                  end else begin
                     w_cnt_nxt   = '0;
                     w_state_nxt = ST_EXT;
                  end
               end
            end
            ST_EXT: begin
               if (smpl) begin
                  w_ext_shift = 1'b1;
                  w_cnt_nxt   = r_cnt + CNTW'(1);
                  if (r_cnt == CNTW'(EXTW - 1)) w_state_nxt = ST_RTR2;
               end
            end
            ST_RTR2: begin
               if (smpl) begin
                  w_rtr_nxt      = rxbit;
                  w_id_valid_nxt = 1'b1;
                  w_state_nxt    = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (rec_ok) begin
                  if (prom) begin
                     w_load      = 1'b1;
                     w_state_nxt = ST_WRITE;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            ST_WRITE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_word = {w_base_id, w_ext_id, r_ide, r_rtr, 1'b0};

   // Output words, strobes and status
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_recid2   <= '0;
         r_recid1   <= '0;
         r_can      <= 1'b0;
         r_id_valid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         if (w_load) begin
            r_recid2 <= w_word[WORDW-1 -: REGW];
            r_recid1 <= w_word[REGW-1:0];
         end
         r_can      <= (w_state_nxt == ST_WRITE);
         r_id_valid <= w_id_valid_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
      end
   end

   assign recid2_o = r_recid2;
   assign recid1_o = r_recid1;
   assign can2_o   = r_can;
   assign can1_o   = r_can;
   assign id_valid = r_id_valid;
   assign busy     = r_busy;

endmodule

// File: tb/tb_rec_id_capture.sv
// Bench for rec_id_capture: directed frames with literal expectations, then
// randomized frames checked every cycle against a bit-list reference model.
module tb_rec_id_capture;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        sof = 1'b0, smpl = 1'b0, rxbit = 1'b0, prom = 1'b0;
   logic        rec_ok = 1'b0, rec_err = 1'b0;
   logic [15:0] recid2_o, recid1_o;
   logic        can2_o, can1_o, id_valid, busy;

   int total = 0;
   int bad   = 0;
   int n_strobe = 0;
   int n_iv     = 0;
   bit chk_en   = 1'b0;

   rec_id_capture dut (
      .clk      (clk),
      .rst      (rst),
      .sof      (sof),
      .smpl     (smpl),
      .rxbit    (rxbit),
      .prom     (prom),
      .rec_ok   (rec_ok),
      .rec_err  (rec_err),
      .recid2_o (recid2_o),
      .recid1_o (recid1_o),
      .can2_o   (can2_o),
      .can1_o   (can1_o),
      .id_valid (id_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the frame is the list of bits since sof; the ID is
   // complete at 13 bits with IDE=0 or 32 bits with IDE=1.
   bit          q[$];
   bit          m_coll = 0, m_hold = 0, m_wr = 0, m_iv = 0, m_busy = 0;
   logic [15:0] m_r2 = '0, m_r1 = '0;

   function automatic logic [31:0] fmt_words(input bit b[$]);
      logic [10:0] base = '0;
      logic [17:0] ext  = '0;
      logic        ide, rtr;
      for (int i = 0; i < 11; i++) base = {base[9:0], b[i]};
      ide = b[12];
      if (ide) begin
         for (int i = 13; i < 31; i++) ext = {ext[16:0], b[i]};
         rtr = b[31];
      end else begin
         rtr = b[11];
      end
      return {base, ext, ide, rtr, 1'b0};
   endfunction

   always @(posedge clk) begin
      logic [31:0] w;
      m_iv = 1'b0;
      if (!rst) begin
         m_coll = 0; m_hold = 0; m_wr = 0; m_r2 = '0; m_r1 = '0;
         q.delete();
      end else if (rec_err) begin
         m_coll = 0; m_hold = 0; m_wr = 0;
      end else if (sof && !m_wr) begin
         m_coll = 1; m_hold = 0;
         q.delete();
      end else if (m_wr) begin
         m_wr = 0;
      end else if (m_hold) begin
         if (rec_ok) begin
            m_hold = 0;
            if (prom) begin
               w    = fmt_words(q);
               m_r2 = w[31:16];
               m_r1 = w[15:0];
               m_wr = 1;
            end
         end
      end else if (m_coll && smpl) begin
         q.push_back(rxbit);
         if ((q.size() == 13 && q[12] == 1'b0) || q.size() == 32) begin
            m_coll = 0; m_hold = 1; m_iv = 1;
         end
      end
      m_busy = m_coll | m_hold | m_wr;
   end

   // Per-cycle comparison against the model, plus strobe/id_valid counters
   always @(negedge clk) begin
      if (can2_o === 1'b1) n_strobe++;
      if (id_valid === 1'b1) n_iv++;
      if (chk_en) begin
         chk("recid2_o", 32'(recid2_o), 32'(m_r2));
         chk("recid1_o", 32'(recid1_o), 32'(m_r1));
         chk("can2_o",   32'(can2_o),   32'(m_wr));
         chk("can1_o",   32'(can1_o),   32'(m_wr));
         chk("id_valid", 32'(id_valid), 32'(m_iv));
         chk("busy",     32'(busy),     32'(m_busy));
      end
   end

   // One clock of stimulus; pulses return low afterwards
   task automatic cyc(input logic s_sof, input logic s_smpl, input logic s_bit,
                      input logic s_ok, input logic s_err);
      sof = s_sof; smpl = s_smpl; rxbit = s_bit; rec_ok = s_ok; rec_err = s_err;
      @(posedge clk);
      #1;
      sof = 1'b0; smpl = 1'b0; rec_ok = 1'b0; rec_err = 1'b0;
   endtask

   bit fb[$];

   task automatic make_frame(input logic [10:0] b, input logic [17:0] e,
                             input logic is_ext, input logic r, input logic srr);
      fb.delete();
      for (int i = 10; i >= 0; i--) fb.push_back(b[i]);
      if (is_ext) begin
         fb.push_back(srr);
         fb.push_back(1'b1);
         for (int i = 17; i >= 0; i--) fb.push_back(e[i]);
         fb.push_back(r);
      end else begin
         fb.push_back(r);
         fb.push_back(1'b0);
      end
   endtask

   task automatic send_prefix(input int n, input int gap);
      for (int i = 0; i < n && i < fb.size(); i++) begin
         repeat ($urandom_range(gap)) cyc(1'b0, 1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
         cyc(1'b0, 1'b1, fb[i], 1'b0, 1'b0);
      end
   endtask

   int s0, v0;

   initial begin
      // Reset
      rst = 1'b0;
      repeat (3) cyc(0, 0, 0, 0, 0);
      chk("rst recid2", 32'(recid2_o), 32'h0);
      chk("rst recid1", 32'(recid1_o), 32'h0);
      chk("rst strobe", 32'(can2_o | can1_o), 32'h0);
      chk("rst busy",   32'(busy), 32'h0);
      rst = 1'b1;
      chk_en = 1'b1;
      cyc(0, 0, 0, 0, 0);

      // Standard frame 0x123, rtr=0, promiscuous
      prom = 1'b1;
      make_frame(11'h123, 18'h0, 1'b0, 1'b0, 1'b0);
      cyc(1, 0, 0, 0, 0);
      send_prefix(13, 0);
      chk("std id_valid", 32'(id_valid), 32'h1);
      chk("std busy", 32'(busy), 32'h1);
      cyc(0, 0, 0, 1, 0);
      chk("std can2", 32'(can2_o), 32'h1);
      chk("std can1", 32'(can1_o), 32'h1);
      chk("std recid2", 32'(recid2_o), 32'h2460);
      chk("std recid1", 32'(recid1_o), 32'h0000);
      cyc(0, 0, 0, 0, 0);
      chk("std strobe end", 32'(can2_o), 32'h0);
      chk("std idle", 32'(busy), 32'h0);

      // Extended frame, all-ones ID, rtr=1
      cyc(0, 0, 0, 0, 0);
      v0 = n_iv;
      make_frame(11'h7FF, 18'h3FFFF, 1'b1, 1'b1, 1'b1);
      cyc(1, 0, 0, 0, 0);
      send_prefix(32, 1);
      cyc(0, 0, 0, 1, 0);
      chk("ext recid2", 32'(recid2_o), 32'hFFFF);
      chk("ext recid1", 32'(recid1_o), 32'hFFFE);
      cyc(0, 0, 0, 0, 0);
      chk("ext id_valid count", 32'(n_iv - v0), 32'd1);

      // Same standard frame without promiscuous mode
      prom = 1'b0;
      s0 = n_strobe; v0 = n_iv;
      make_frame(11'h123, 18'h0, 1'b0, 1'b0, 1'b0);
      cyc(1, 0, 0, 0, 0);
      send_prefix(13, 0);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("noprom strobes", 32'(n_strobe - s0), 32'd0);
      chk("noprom id_valid", 32'(n_iv - v0), 32'd1);
      chk("noprom recid2", 32'(recid2_o), 32'hFFFF);
      chk("noprom recid1", 32'(recid1_o), 32'hFFFE);

      // Abort after 6 base bits, then a stray rec_ok
      prom = 1'b1;
      s0 = n_strobe;
      cyc(1, 0, 0, 0, 0);
      send_prefix(6, 0);
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("abort busy", 32'(busy), 32'h0);
      chk("abort strobes", 32'(n_strobe - s0), 32'd0);
      chk("abort recid2", 32'(recid2_o), 32'hFFFF);

      // sof in the middle of the extended field, then standard ID 0x001
      s0 = n_strobe;
      make_frame(11'h2AA, 18'h15555, 1'b1, 1'b0, 1'b1);
      cyc(1, 0, 0, 0, 0);
      send_prefix(20, 0);
      make_frame(11'h001, 18'h0, 1'b0, 1'b0, 1'b0);
      cyc(1, 0, 0, 0, 0);
      send_prefix(13, 0);
      cyc(0, 0, 0, 1, 0);
      chk("resync recid2", 32'(recid2_o), 32'h0020);
      chk("resync recid1", 32'(recid1_o), 32'h0000);
      cyc(0, 0, 0, 0, 0);
      chk("resync strobes", 32'(n_strobe - s0), 32'd1);

      // Reset while holding, with rec_ok in the same cycle
      make_frame(11'h555, 18'h0, 1'b0, 1'b1, 1'b0);
      cyc(1, 0, 0, 0, 0);
      send_prefix(13, 0);
      rst = 1'b0;
      cyc(0, 0, 0, 1, 0);
      chk("rsthold recid2", 32'(recid2_o), 32'h0);
      chk("rsthold recid1", 32'(recid1_o), 32'h0);
      chk("rsthold strobe", 32'(can2_o | can1_o), 32'h0);
      chk("rsthold busy", 32'(busy | id_valid), 32'h0);
      rst = 1'b1;
      cyc(0, 0, 0, 0, 0);

      // Randomized frames with aborts, resyncs and stray pulses
      for (int f = 0; f < 300; f++) begin
         int kind, t, gap;
         prom = 1'($urandom_range(1));
         gap  = $urandom_range(2);
         make_frame(11'($urandom), 18'($urandom), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
         repeat ($urandom_range(2)) cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0);
         cyc(1, 0, 0, 0, 0);
         kind = $urandom_range(9);
         case (kind)
            0: begin send_prefix($urandom_range(fb.size() - 1), gap); cyc(0, 0, 0, 0, 1); end
            1: begin send_prefix($urandom_range(fb.size() - 1), gap); cyc(1, 0, 0, 0, 0);
                     send_prefix(fb.size(), gap); end
            2: begin send_prefix($urandom_range(fb.size() - 1), gap); cyc(0, 0, 0, 1, 0); end
            default: send_prefix(fb.size(), gap);
         endcase
         repeat ($urandom_range(3)) cyc(0, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, 0);
         t = $urandom_range(5);
         case (t)
            0: cyc(0, 0, 0, 0, 1);
            1: begin cyc(1, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1); end
            2: begin cyc(0, 0, 0, 1, 0); cyc(1, 0, 0, 0, 0); end
            3: begin cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 1); end
            default: cyc(0, 0, 0, 1, 0);
         endcase
         if ($urandom_range(40) == 0) begin
            rst = 1'b0;
            cyc(0, 0, 0, 0, 0);
            rst = 1'b1;
         end
         cyc(0, 0, 0, 0, 0);
      end

      repeat (4) cyc(0, 0, 0, 0, 0);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
